// File: rtl/ascii_seq_decoder.sv
// rtl/ascii_seq_decoder.sv - glitch-filtered ASCII hex-symbol sequence decoder with lock and sticky error status
// Optional lowercase 'a'..'f' decode is enabled by defining ASCII_LOWER_EN.
module ascii_seq_decoder #(
  parameter int SETTLE_CYCLES = 4,
  parameter int PERIOD_CYCLES = 25000001,
  parameter int PERIOD_TOL    = 16,
  parameter int LOCK_COUNT    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] char_in,
  input  logic       clr_err,
  output logic [3:0] value,
  output logic       value_valid,
  output logic       locked,
  output logic       seq_err,
  output logic       period_err,
  output logic       char_err
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_HIT = SW'(SETTLE_CYCLES - 1);
  localparam logic [31:0]   PER_MIN    = 32'(PERIOD_CYCLES - PERIOD_TOL);
  localparam logic [31:0]   PER_MAX    = 32'(PERIOD_CYCLES + PERIOD_TOL);
  localparam logic [7:0]    LOCK_GOOD  = 8'(LOCK_COUNT);

  typedef enum logic [1:0] {ACQUIRE, TRACK, LOCKED} state_t;

  state_t        state;
  logic [7:0]    char_q;
  logic [7:0]    acc_char;
  logic [SW-1:0] stab_cnt;
  logic [31:0]   interval;
  logic [7:0]    good;

  logic       accept;
  logic       dec_ok;
  logic       dec_blank;
  logic [3:0] dec_val;
  logic       valid_dec;
  logic       bad_char;
  logic       seq_ok;
  logic       period_ok;
  logic       stall;
  logic [7:0] good_inc;

  always_comb begin
    dec_ok    = 1'b0;
    dec_blank = 1'b0;
    dec_val   = 4'd0;
    if (char_q >= 8'h30 && char_q <= 8'h39) begin
      dec_ok  = 1'b1;
      dec_val = 4'(char_q - 8'h2A);
    end else if (char_q >= 8'h41 && char_q <= 8'h46) begin
      dec_ok  = 1'b1;
      dec_val = 4'(char_q - 8'h41);
`ifdef ASCII_LOWER_EN
    end else if (char_q >= 8'h61 && char_q <= 8'h66) begin
      dec_ok  = 1'b1;
      dec_val = 4'(char_q - 8'h61);
`endif
    end else if (char_q == 8'h00) begin
      dec_blank = 1'b1;
    end
  end

  // An event fires once per newly settled character; re-presenting the accepted one is ignored.
  assign accept    = (stab_cnt == SETTLE_HIT) && (char_q != acc_char);
  assign valid_dec = accept && dec_ok;
  assign bad_char  = accept && !dec_ok && !dec_blank;
  assign seq_ok    = (dec_val == value + 4'd1);
  assign period_ok = (interval >= PER_MIN) && (interval <= PER_MAX);
  assign stall     = (state == LOCKED) && !valid_dec && (interval > PER_MAX);
  assign good_inc  = (good == 8'hFF) ? good : good + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACQUIRE;
      char_q      <= 8'h00;
      acc_char    <= 8'h00;
      stab_cnt    <= '0;
      interval    <= 32'd0;
      good        <= 8'd0;
      value       <= 4'd0;
      value_valid <= 1'b0;
      locked      <= 1'b0;
      seq_err     <= 1'b0;
      period_err  <= 1'b0;
      char_err    <= 1'b0;
    end else begin
      char_q <= char_in;
      if (char_in != char_q) begin
        stab_cnt <= '0;
      end else if (stab_cnt != SETTLE_MAX) begin
        stab_cnt <= stab_cnt + 1'b1;
      end
      if (accept) begin
        acc_char <= char_q;
      end

      value_valid <= valid_dec;
      if (valid_dec) begin
        interval <= 32'd1;
      end else if (interval != 32'hFFFF_FFFF) begin
        interval <= interval + 32'd1;
      end

      // A new error outranks a coincident clear.
      seq_err    <= (seq_err & ~clr_err) | (valid_dec && state != ACQUIRE && !seq_ok);
      period_err <= (period_err & ~clr_err) | (valid_dec && state != ACQUIRE && !period_ok) | stall;
      char_err   <= (char_err & ~clr_err) | bad_char;

      if (valid_dec) begin
        value <= dec_val;
        if (state == ACQUIRE) begin
          state  <= TRACK;
          good   <= 8'd0;
          locked <= 1'b0;
        end else if (seq_ok && period_ok) begin
          good <= good_inc;
          if (good_inc >= LOCK_GOOD) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end
        end else begin
          state  <= TRACK;
          good   <= 8'd0;
          locked <= 1'b0;
        end
      end else if (stall) begin
        state  <= TRACK;
        good   <= 8'd0;
        locked <= 1'b0;
      end else if (bad_char) begin
        good <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_ascii_seq_decoder.sv
// tb/tb_ascii_seq_decoder.sv - randomized self-checking bench for ascii_seq_decoder against a symbol-level model
module tb_ascii_seq_decoder;

  localparam int S = 2;
  localparam int P = 20;
  localparam int T = 2;
  localparam int L = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] char_in = 8'h00;
  logic       clr_err = 1'b0;
  logic [3:0] value;
  logic       value_valid, locked, seq_err, period_err, char_err;

  int checks = 0;
  int errors = 0;

  ascii_seq_decoder #(.SETTLE_CYCLES(S), .PERIOD_CYCLES(P), .PERIOD_TOL(T), .LOCK_COUNT(L)) dut (
    .clk(clk), .rst_n(rst_n), .char_in(char_in), .clr_err(clr_err),
    .value(value), .value_valid(value_valid), .locked(locked),
    .seq_err(seq_err), .period_err(period_err), .char_err(char_err)
  );

  always #5 clk = ~clk;

  // Model: tracks run length of sampled characters and applies decode rules per accepted symbol.
  int         m_value, m_good, run_len;
  bit         m_vv, m_acq, m_lock, m_seq, m_per, m_chr, pend;
  longint     m_int;
  logic [7:0] m_acc, run_char, pend_char;

  function automatic int decode(input logic [7:0] c);
    if (c == 8'h00) return -1;
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48 + 6;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 65;
`ifdef ASCII_LOWER_EN
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 97;
`endif
    return -2;
  endfunction

  function automatic logic [7:0] vchar(input int v);
    return (v < 6) ? 8'(8'h41 + v) : 8'(8'h30 + v - 6);
  endfunction

  function automatic logic [8:0] exp_vec();
    return {4'(m_value), m_vv, m_lock, m_seq, m_per, m_chr};
  endfunction

  function automatic logic [8:0] got_vec();
    return {value, value_valid, locked, seq_err, period_err, char_err};
  endfunction

  task automatic model_reset();
    m_value = 0; m_good = 0; run_len = 0; m_vv = 0; m_acq = 0; m_lock = 0;
    m_seq = 0; m_per = 0; m_chr = 0; pend = 0; m_int = 0;
    m_acc = 8'h00; run_char = 8'h00; pend_char = 8'h00;
  endtask

  task automatic model_edge(input logic [7:0] ch, input bit clr);
    int d;
    bit n_seq, n_per, n_chr, sok, pok;
    n_seq = 0; n_per = 0; n_chr = 0;
    d = pend ? decode(pend_char) : -1;
    m_vv = (d >= 0);
    if (d >= 0) begin
      if (!m_acq) begin
        m_acq = 1; m_good = 0; m_lock = 0;
      end else begin
        sok = (d == (m_value + 1) % 16);
        pok = (m_int >= P - T) && (m_int <= P + T);
        if (sok && pok) begin
          m_good++;
          if (m_good >= L) m_lock = 1;
        end else begin
          n_seq = !sok; n_per = !pok; m_good = 0; m_lock = 0;
        end
      end
      m_value = d;
      m_int = 1;
    end else begin
      if (d == -2) begin n_chr = 1; m_good = 0; end
      if (m_lock && m_int > P + T) begin n_per = 1; m_lock = 0; m_good = 0; end
      if (m_int < 64'hFFFF_FFFF) m_int++;
    end
    m_seq = (clr ? 1'b0 : m_seq) | n_seq;
    m_per = (clr ? 1'b0 : m_per) | n_per;
    m_chr = (clr ? 1'b0 : m_chr) | n_chr;
    if (ch == run_char) run_len++;
    else begin run_char = ch; run_len = 1; end
    pend = (run_len == S) && (run_char != m_acc);
    if (pend) begin pend_char = run_char; m_acc = run_char; end
  endtask

  task automatic drive(input logic [7:0] ch, input bit clr);
    @(negedge clk);
    char_in = ch;
    clr_err = clr;
    @(posedge clk);
    model_edge(ch, clr);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    checks++;
    if (got_vec() !== 9'h000) begin errors++; $display("FAIL reset_state: got %b exp %b", got_vec(), 9'h000); end
    for (int k = 0; k < 5; k++) begin
      drive(8'h00, 0);
      checks++;
      if (got_vec() !== 9'h000) begin errors++; $display("FAIL idle_blank: got %b exp %b", got_vec(), 9'h000); end
    end
  endtask

  task automatic test_acquire_lock();
    int first;
    bit lock_at[16];
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      drive(8'h41, 0);
      checks++;
      if (got_vec() !== exp_vec()) begin errors++; $display("FAIL acquire_A: got %b exp %b", got_vec(), exp_vec()); end
      if (value_valid && first == 0) first = k;
    end
    checks++;
    if (first != S + 1) begin errors++; $display("FAIL latency: got %0d exp %0d", first, S + 1); end
    for (int v = 1; v <= 4; v++) begin
      for (int k = 0; k < 20; k++) begin
        drive(vchar(v), 0);
        checks++;
        if (got_vec() !== exp_vec()) begin errors++; $display("FAIL lock_seq %0d: got %b exp %b", v, got_vec(), exp_vec()); end
        if (value_valid) lock_at[v] = locked;
      end
    end
    checks++;
    if (lock_at[2] !== 1'b0 || lock_at[3] !== 1'b1) begin
      errors++; $display("FAIL lock_rise: got C=%b D=%b exp C=0 D=1", lock_at[2], lock_at[3]);
    end
    checks++;
    if ({value, seq_err, period_err, char_err} !== {4'd4, 3'b000}) begin
      errors++; $display("FAIL lock_state: got %b exp %b", {value, seq_err, period_err, char_err}, {4'd4, 3'b000});
    end
  endtask

  task automatic test_wrap();
    for (int v = 5; v <= 16; v++) begin
      for (int k = 0; k < 20; k++) begin
        drive(vchar(v % 16), 0);
        checks++;
        if (got_vec() !== exp_vec()) begin errors++; $display("FAIL wrap %0d: got %b exp %b", v, got_vec(), exp_vec()); end
      end
    end
    checks++;
    if ({value, locked, seq_err} !== {4'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL wrap_9_A: got %b exp %b", {value, locked, seq_err}, {4'd0, 1'b1, 1'b0});
    end
    for (int k = 0; k < 20; k++) drive(8'h43, 0);
    checks++;
    if ({value, locked, seq_err} !== {4'd2, 1'b0, 1'b1}) begin
      errors++; $display("FAIL skip_seq: got %b exp %b", {value, locked, seq_err}, {4'd2, 1'b0, 1'b1});
    end
  endtask

  task automatic test_glitch_char_err();
    int pulses;
    pulses = 0;
    drive(8'h35, 0);
    for (int k = 0; k < 10; k++) begin
      drive(8'h43, 0);
      pulses += value_valid;
      checks++;
      if (got_vec() !== exp_vec()) begin errors++; $display("FAIL glitch: got %b exp %b", got_vec(), exp_vec()); end
    end
    checks++;
    if (pulses != 0 || char_err !== 1'b0) begin errors++; $display("FAIL glitch_ignored: got pulses=%0d char_err=%b exp 0 0", pulses, char_err); end
    for (int k = 0; k < 10; k++) drive(8'h5A, 0);
    checks++;
    if (char_err !== 1'b1 || value_valid !== 1'b0) begin errors++; $display("FAIL bad_char: got %b%b exp 10", char_err, value_valid); end
    drive(8'h5A, 1);
    drive(8'h5A, 0);
    checks++;
    if ({seq_err, period_err, char_err} !== 3'b000) begin
      errors++; $display("FAIL clr_err: got %b exp 000", {seq_err, period_err, char_err});
    end
  endtask

  task automatic test_stall();
    int vv_k, rise_k;
    for (int v = 3; v <= 6; v++) begin
      for (int k = 0; k < 20; k++) begin
        drive(vchar(v), 0);
        checks++;
        if (got_vec() !== exp_vec()) begin errors++; $display("FAIL relock %0d: got %b exp %b", v, got_vec(), exp_vec()); end
      end
    end
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL relock: got %b exp 1", locked); end
    vv_k = -1; rise_k = -1;
    for (int k = 0; k < 30; k++) begin
      drive(vchar(7), k == 0);
      if (value_valid) vv_k = k;
      if (period_err && rise_k < 0) rise_k = k;
      checks++;
      if (got_vec() !== exp_vec()) begin errors++; $display("FAIL stall: got %b exp %b", got_vec(), exp_vec()); end
    end
    checks++;
    if (rise_k - vv_k != P + T + 1 || locked !== 1'b0) begin
      errors++; $display("FAIL stall_point: got %0d locked=%b exp %0d locked=0", rise_k - vv_k, locked, P + T + 1);
    end
    for (int k = 0; k < 19; k++) begin
      drive(vchar(8), k == 0);
      checks++;
      if (got_vec() !== exp_vec()) begin errors++; $display("FAIL after_stall: got %b exp %b", got_vec(), exp_vec()); end
    end
  endtask

  task automatic test_random();
    int r, gap, pulses;
    logic [7:0] ch;
    pulses = 0;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70) ch = vchar((m_value + 1) % 16);
      else if (r < 78) ch = vchar($urandom_range(0, 15));
      else if (r < 84) begin
        case ($urandom_range(0, 3))
          0: ch = 8'h5A;
          1: ch = 8'(8'h61 + $urandom_range(0, 5));
          2: ch = 8'h7F;
          default: ch = 8'h47;
        endcase
      end
      else if (r < 88) ch = 8'h00;
      else ch = char_in;
      gap = ($urandom_range(0, 9) == 0) ? $urandom_range(25, 32) : $urandom_range(17, 23);
      for (int k = 0; k < gap; k++) begin
        if (k == gap / 2 && $urandom_range(0, 9) == 0) drive(8'h35, 0);
        else drive(ch, $urandom_range(0, 15) == 0);
        pulses += value_valid;
        checks++;
        if (got_vec() !== exp_vec()) begin errors++; $display("FAIL random %0d: got %b exp %b", n, got_vec(), exp_vec()); end
      end
    end
    checks++;
    if (pulses == 0) begin errors++; $display("FAIL random_activity: got 0 pulses exp >0"); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 7; k++) drive(8'h43, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (got_vec() !== 9'h000) begin errors++; $display("FAIL async_reset: got %b exp %b", got_vec(), 9'h000); end
    model_reset();
    #1 rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(8'h43, 0);
      checks++;
      if (got_vec() !== exp_vec()) begin errors++; $display("FAIL post_reset: got %b exp %b", got_vec(), exp_vec()); end
    end
    checks++;
    if ({value, locked, seq_err, period_err} !== {4'd2, 3'b000}) begin
      errors++; $display("FAIL reacquire: got %b exp %b", {value, locked, seq_err, period_err}, {4'd2, 3'b000});
    end
    for (int k = 0; k < 20; k++) drive(8'h61, 0);
    checks++;
`ifdef ASCII_LOWER_EN
    if ({value, char_err} !== {4'd0, 1'b0}) begin errors++; $display("FAIL lower_a: got %b exp %b", {value, char_err}, {4'd0, 1'b0}); end
`else
    if ({value, char_err} !== {4'd2, 1'b1}) begin errors++; $display("FAIL lower_a: got %b exp %b", {value, char_err}, {4'd2, 1'b1}); end
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_acquire_lock();
    test_wrap();
    test_glitch_char_err();
    test_stall();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
